// File: rtl/cache_access_scheduler_if.sv
// Request/array bundle between the CPU and snoop front-ends, the scheduler and the set array.
interface cache_access_scheduler_if #(
  parameter int ADDR_W     = 32,
  parameter int INDEX_BITS = 14,
  parameter int TAG_BITS   = 12
);
  logic              cpu_req_valid;
  logic [ADDR_W-1:0] cpu_req_addr;
  logic [1:0]        cpu_req_op;
  logic              cpu_req_ready;
  logic              snp_req_valid;
  logic [ADDR_W-1:0] snp_req_addr;
  logic [1:0]        snp_req_op;
  logic              snp_req_ready;
  logic              arr_rd_en;
  logic              arr_wr_en;
  logic [INDEX_BITS-1:0] arr_index;
  logic [TAG_BITS-1:0]   arr_tag;
  logic [1:0]        arr_op;
  logic              arr_src;
  logic              upd_hold;
  logic              busy;

  modport master (
    output cpu_req_valid, cpu_req_addr, cpu_req_op, snp_req_valid, snp_req_addr, snp_req_op, upd_hold,
    input  cpu_req_ready, snp_req_ready, arr_rd_en, arr_wr_en, arr_index, arr_tag, arr_op, arr_src, busy
  );

  modport slave (
    input  cpu_req_valid, cpu_req_addr, cpu_req_op, snp_req_valid, snp_req_addr, snp_req_op, upd_hold,
    output cpu_req_ready, snp_req_ready, arr_rd_en, arr_wr_en, arr_index, arr_tag, arr_op, arr_src, busy
  );
endinterface

// File: rtl/cache_access_scheduler.sv
// Serializes CPU and snoop accesses to the single-ported LLC set array as LOOKUP/UPDATE pairs.
module cache_access_scheduler #(
  parameter int ADDR_W          = 32,
  parameter int OFFSET_BITS     = 6,
  parameter int INDEX_BITS      = 14,
  parameter int TAG_BITS        = 12,
  parameter int MAX_SNOOP_BURST = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  cache_access_scheduler_if.slave bus
);
  localparam int BW = $clog2(MAX_SNOOP_BURST + 1);
  localparam logic [BW-1:0] BURST_MAX = BW'(MAX_SNOOP_BURST);

  typedef enum logic [1:0] {IDLE, LOOKUP, UPDATE} state_t;

  typedef struct packed {
    logic [INDEX_BITS-1:0] index;
    logic [TAG_BITS-1:0]   tag;
    logic [1:0]            op;
    logic                  src;
  } acc_t;

  state_t        state, state_nxt;
  logic [BW-1:0] burst_cnt;
  acc_t          acc, req;
  logic          accept, snp_gnt, cpu_gnt, gnt;

  // rst_n in the accept term keeps both readies low for the whole reset pulse.
  always_comb begin
    accept  = rst_n && (state == IDLE || (state == UPDATE && !bus.upd_hold));
    snp_gnt = accept && bus.snp_req_valid && (burst_cnt < BURST_MAX || !bus.cpu_req_valid);
    cpu_gnt = accept && bus.cpu_req_valid && !snp_gnt;
    gnt     = snp_gnt || cpu_gnt;
  end

  always_comb begin
    req = '0;
    if (snp_gnt) begin
      req.index = bus.snp_req_addr[OFFSET_BITS+INDEX_BITS-1:OFFSET_BITS];
      req.tag   = bus.snp_req_addr[ADDR_W-1:ADDR_W-TAG_BITS];
      req.op    = bus.snp_req_op;
      req.src   = 1'b1;
    end else begin
      req.index = bus.cpu_req_addr[OFFSET_BITS+INDEX_BITS-1:OFFSET_BITS];
      req.tag   = bus.cpu_req_addr[ADDR_W-1:ADDR_W-TAG_BITS];
      req.op    = bus.cpu_req_op;
      req.src   = 1'b0;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (gnt) state_nxt = LOOKUP;
      LOOKUP:  state_nxt = UPDATE;
      UPDATE:  if (!bus.upd_hold) state_nxt = gnt ? LOOKUP : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      burst_cnt <= '0;
      acc       <= '0;
    end else begin
      state <= state_nxt;
      if (gnt) acc <= req;
      // Only a snoop that jumped a waiting CPU request counts toward the burst.
      if (cpu_gnt)
        burst_cnt <= '0;
      else if (snp_gnt) begin
        if (!bus.cpu_req_valid)         burst_cnt <= '0;
        else if (burst_cnt != BURST_MAX) burst_cnt <= burst_cnt + 1'b1;
      end
    end
  end

  assign bus.cpu_req_ready = cpu_gnt;
  assign bus.snp_req_ready = snp_gnt;
  assign bus.arr_rd_en     = (state == LOOKUP);
  assign bus.arr_wr_en     = (state == UPDATE) && !bus.upd_hold;
  assign bus.busy          = (state != IDLE);
  assign bus.arr_index     = acc.index;
  assign bus.arr_tag       = acc.tag;
  assign bus.arr_op        = acc.op;
  assign bus.arr_src       = acc.src;

  logic unused_offset;
  assign unused_offset = ^{bus.cpu_req_addr[OFFSET_BITS-1:0], bus.snp_req_addr[OFFSET_BITS-1:0]};
endmodule

// File: tb/tb_cache_access_scheduler.sv
// Directed bench: expected array accesses queued at request time, checked on each LOOKUP strobe.
module tb_cache_access_scheduler;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  cache_access_scheduler_if #(.ADDR_W(32), .INDEX_BITS(14), .TAG_BITS(12)) bus ();

  cache_access_scheduler #(
    .ADDR_W(32), .OFFSET_BITS(6), .INDEX_BITS(14), .TAG_BITS(12), .MAX_SNOOP_BURST(4)
  ) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  typedef struct {
    logic [13:0] idx;
    logic [11:0] tag;
    logic [1:0]  op;
    logic        src;
  } exp_t;

  exp_t sbq[$];
  exp_t e;
  int total = 0, bad = 0;
  int rd_cnt = 0, wr_cnt = 0, cyc = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t mk(input logic [31:0] a, input logic [1:0] op, input logic src);
    exp_t r;
    r.idx = a[19:6];
    r.tag = a[31:20];
    r.op  = op;
    r.src = src;
    return r;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (bus.arr_wr_en) wr_cnt <= wr_cnt + 1;
    if (bus.arr_rd_en) begin
      rd_cnt <= rd_cnt + 1;
      if (sbq.size() == 0) chk("sb_unexpected_lookup", 1, 0);
      else begin
        e = sbq.pop_front();
        chk("sb_index", bus.arr_index, e.idx);
        chk("sb_tag",   bus.arr_tag,   e.tag);
        chk("sb_op",    bus.arr_op,    e.op);
        chk("sb_src",   bus.arr_src,   e.src);
      end
    end
  end

  task automatic do_reset();
    @(posedge clk); #1;
    rst_n = 1'b0;
    bus.cpu_req_valid = 1'b0;
    bus.snp_req_valid = 1'b0;
    bus.upd_hold = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic wait_idle();
    int n = 0;
    @(negedge clk);
    while (bus.busy && n < 50) begin @(negedge clk); n++; end
    chk("idle_timeout", bus.busy, 0);
  endtask

  // pat bit k = 1 means grant k must go to the snoop; each granted requester advances one line.
  task automatic run_grants(input logic [15:0] pat, input int n);
    int last = 0;
    int w;
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      w = 0;
      while (!(bus.cpu_req_ready || bus.snp_req_ready) && w < 20) begin @(negedge clk); w++; end
      chk("grant_timeout", (w < 20), 1);
      chk("grant_snp_ready", bus.snp_req_ready, pat[k]);
      chk("grant_cpu_ready", bus.cpu_req_ready, !pat[k]);
      if (k > 0) chk("grant_spacing", cyc - last, 2);
      last = cyc;
      if (pat[k]) sbq.push_back(mk(bus.snp_req_addr, bus.snp_req_op, 1'b1));
      else        sbq.push_back(mk(bus.cpu_req_addr, bus.cpu_req_op, 1'b0));
      @(posedge clk); #1;
      if (pat[k]) bus.snp_req_addr = bus.snp_req_addr + 32'd64;
      else        bus.cpu_req_addr = bus.cpu_req_addr + 32'd64;
      if (k == n - 1) begin
        bus.snp_req_valid = 1'b0;
        bus.cpu_req_valid = 1'b0;
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired before end of test");
    $fatal(1, "watchdog");
  end

  initial begin
    int wr0, rd0;
    // Reset state, with both valids high to see the readies held low.
    rst_n = 1'b0;
    bus.cpu_req_valid = 1'b1;  bus.cpu_req_addr = 32'h0;  bus.cpu_req_op = 2'd0;
    bus.snp_req_valid = 1'b1;  bus.snp_req_addr = 32'h0;  bus.snp_req_op = 2'd0;
    bus.upd_hold = 1'b0;
    #2;
    chk("rst_cpu_ready", bus.cpu_req_ready, 0);
    chk("rst_snp_ready", bus.snp_req_ready, 0);
    chk("rst_rd_en", bus.arr_rd_en, 0);
    chk("rst_wr_en", bus.arr_wr_en, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_outs", {bus.arr_index, bus.arr_tag, bus.arr_op, bus.arr_src}, 0);
    bus.cpu_req_valid = 1'b0;
    bus.snp_req_valid = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;

    // Single CPU request.
    bus.cpu_req_valid = 1'b1; bus.cpu_req_addr = 32'h1234_5678; bus.cpu_req_op = 2'd1;
    sbq.push_back(mk(32'h1234_5678, 2'd1, 1'b0));
    @(negedge clk);
    chk("t1_cpu_ready", bus.cpu_req_ready, 1);
    chk("t1_snp_ready", bus.snp_req_ready, 0);
    @(posedge clk); #1;
    bus.cpu_req_valid = 1'b0;
    @(negedge clk);
    chk("t1_rd_en", bus.arr_rd_en, 1);
    chk("t1_index", bus.arr_index, 14'h1159);
    chk("t1_tag", bus.arr_tag, 12'h123);
    chk("t1_src", bus.arr_src, 0);
    chk("t1_wr_early", bus.arr_wr_en, 0);
    @(negedge clk);
    chk("t1_wr_en", bus.arr_wr_en, 1);
    chk("t1_rd_late", bus.arr_rd_en, 0);
    @(negedge clk);
    chk("t1_busy_end", bus.busy, 0);

    // Simultaneous valids: snoop first, CPU in the snoop's UPDATE cycle.
    do_reset();
    bus.snp_req_valid = 1'b1; bus.snp_req_addr = 32'hABC0_0040; bus.snp_req_op = 2'd3;
    bus.cpu_req_valid = 1'b1; bus.cpu_req_addr = 32'h0001_2380; bus.cpu_req_op = 2'd2;
    sbq.push_back(mk(32'hABC0_0040, 2'd3, 1'b1));
    sbq.push_back(mk(32'h0001_2380, 2'd2, 1'b0));
    @(negedge clk);
    chk("t2_snp_first", bus.snp_req_ready, 1);
    chk("t2_cpu_wait", bus.cpu_req_ready, 0);
    @(posedge clk); #1;
    bus.snp_req_valid = 1'b0;
    @(negedge clk);
    chk("t2_lookup_cpu_ready", bus.cpu_req_ready, 0);
    chk("t2_src", bus.arr_src, 1);
    chk("t2_op", bus.arr_op, 3);
    @(negedge clk);
    chk("t2_update_cpu_ready", bus.cpu_req_ready, 1);
    chk("t2_update_wr", bus.arr_wr_en, 1);
    @(posedge clk); #1;
    bus.cpu_req_valid = 1'b0;
    wait_idle();

    // Both held: S,S,S,S,C,S,S,S,S,C.
    do_reset();
    bus.snp_req_valid = 1'b1; bus.snp_req_addr = 32'h8000_0000; bus.snp_req_op = 2'd1;
    bus.cpu_req_valid = 1'b1; bus.cpu_req_addr = 32'h0010_0000; bus.cpu_req_op = 2'd0;
    run_grants(16'h01EF, 10);
    wait_idle();

    // upd_hold for three UPDATE cycles with a snoop waiting.
    do_reset();
    bus.cpu_req_valid = 1'b1; bus.cpu_req_addr = 32'h0040_0080; bus.cpu_req_op = 2'd1;
    sbq.push_back(mk(32'h0040_0080, 2'd1, 1'b0));
    @(negedge clk);
    chk("t4_cpu_ready", bus.cpu_req_ready, 1);
    @(posedge clk); #1;
    bus.cpu_req_valid = 1'b0;
    bus.upd_hold = 1'b1;
    bus.snp_req_valid = 1'b1; bus.snp_req_addr = 32'h0800_00C0; bus.snp_req_op = 2'd2;
    @(negedge clk);
    chk("t4_rd_en", bus.arr_rd_en, 1);
    wr0 = wr_cnt;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("t4_hold_wr", bus.arr_wr_en, 0);
      chk("t4_hold_snp_ready", bus.snp_req_ready, 0);
      chk("t4_hold_busy", bus.busy, 1);
      chk("t4_hold_index", bus.arr_index, 14'h0002);
    end
    @(posedge clk); #1;
    bus.upd_hold = 1'b0;
    sbq.push_back(mk(32'h0800_00C0, 2'd2, 1'b1));
    @(negedge clk);
    chk("t4_commit_wr", bus.arr_wr_en, 1);
    chk("t4_commit_snp_ready", bus.snp_req_ready, 1);
    chk("t4_commit_index", bus.arr_index, 14'h0002);
    @(posedge clk); #1;
    bus.snp_req_valid = 1'b0;
    wait_idle();
    chk("t4_wr_count", wr_cnt - wr0, 2);

    // Reset during LOOKUP abandons the access.
    do_reset();
    bus.cpu_req_valid = 1'b1; bus.cpu_req_addr = 32'h1000_0A40; bus.cpu_req_op = 2'd3;
    sbq.push_back(mk(32'h1000_0A40, 2'd3, 1'b0));
    @(negedge clk);
    chk("t5_cpu_ready", bus.cpu_req_ready, 1);
    @(posedge clk); #1;
    bus.cpu_req_valid = 1'b0;
    @(negedge clk);
    chk("t5_rd_en", bus.arr_rd_en, 1);
    wr0 = wr_cnt;
    #2;
    bus.cpu_req_valid = 1'b1;
    bus.snp_req_valid = 1'b1;
    rst_n = 1'b0;
    #1;
    chk("t5_rst_rd", bus.arr_rd_en, 0);
    chk("t5_rst_wr", bus.arr_wr_en, 0);
    chk("t5_rst_busy", bus.busy, 0);
    chk("t5_rst_outs", {bus.arr_index, bus.arr_tag, bus.arr_op, bus.arr_src}, 0);
    chk("t5_rst_readies", {bus.cpu_req_ready, bus.snp_req_ready}, 0);
    @(posedge clk); @(posedge clk); #1;
    bus.snp_req_valid = 1'b0;
    bus.cpu_req_addr = 32'h2000_0100; bus.cpu_req_op = 2'd0;
    sbq.push_back(mk(32'h2000_0100, 2'd0, 1'b0));
    rst_n = 1'b1;
    @(negedge clk);
    chk("t5_post_cpu_ready", bus.cpu_req_ready, 1);
    chk("t5_no_wr_pulse", wr_cnt - wr0, 0);
    @(posedge clk); #1;
    bus.cpu_req_valid = 1'b0;
    wait_idle();

    // Ten back-to-back CPU requests on consecutive lines.
    do_reset();
    rd0 = rd_cnt;
    wr0 = wr_cnt;
    bus.cpu_req_valid = 1'b1; bus.cpu_req_addr = 32'h0000_1000; bus.cpu_req_op = 2'd2;
    run_grants(16'h0000, 10);
    wait_idle();
    chk("t6_rd_count", rd_cnt - rd0, 10);
    chk("t6_wr_count", wr_cnt - wr0, 10);

    chk("sb_drained", sbq.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
